fft_8_core: RTL and testbench
=============================

# fft_8_core

Radix-2 decimation-in-frequency first stage of an 8-point complex FFT. It accepts one framed 8-sample complex stream and emits two back-to-back 4-sample framed streams for a downstream 4-point stage:
- first frame: x[n]+x[n+4];
- second frame: (x[n]−x[n+4])·W8^n.

It sits between the sample source (`data_gen`, layer 3) and the 4-point stage.

## Interface
- `DATA_W`, default 32: width of each real/imag component (signed two's complement).
- `TW_FRAC`, default 14: fraction bits of twiddle constants (16384 = 1.0).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start8` in 1: one-cycle pulse marking input sample n=0.
- `end8` in 1: one-cycle pulse marking input sample n=7.
- `A_real` in DATA_W: input real part.
- `A_img` in DATA_W: input imaginary part.
- `out_real8` out DATA_W: output real part.
- `out_img8` out DATA_W: output imaginary part.
- `start4` out 1: pulse on the first sample of each 4-sample output frame.
- `end4` out 1: pulse on the last sample of each 4-sample output frame.

## Operation
- Input frame: 8 samples on 8 consecutive cycles, starting at the `start8` cycle.
  - No per-sample valid signal.
  - `end8` is expected at n=7 and is informational only; a mismatch does not alter processing.
- Input counter `in_cnt` (0..7):
  - `start8` loads n=0.
  - `in_cnt` then increments each cycle until 7, then goes idle.
  - `start8` mid-frame aborts the partial frame and restarts at n=0.
- Samples n=0..3 are written to input buffer IB[0..3].
- At each sample n=4..7, with k=n−4:
  - SUM = IB[k] + x[n], registered to the output.
  - DIFF[k] = IB[k] − x[n], written to a separate diff buffer DB.
- Sum phase: outputs k=0..3 on consecutive cycles; `start4` at k=0, `end4` at k=3.
- Twiddle phase: follows immediately and outputs DB[k]·W8^k for k=0..3; `start4` at k=0, `end4` at k=3.
- Twiddles:
  - W0 = 1 (pass-through).
  - W1 = (11585, −11585).
  - W2 = −j, computed exactly: (re,im) → (im, −re).
  - W3 = (−11585, −11585).
- Arithmetic:
  - Add and subtract wrap modulo 2^DATA_W.
  - W1/W3 products: full-width signed multiply (≥ DATA_W+16 bits), sum the partial products, arithmetic shift right by TW_FRAC (truncate toward −∞), keep the low DATA_W bits.
- When no frame is being output, `out_real8`/`out_img8` = 0 and `start4`/`end4` = 0.
- Back-to-back input frames (next `start8` the cycle after `end8`) are fully supported. DB is decoupled from IB, so the output stream is continuous.

## Timing
- Take the `start8` cycle as cycle 0.
- Sum outputs appear on cycles 5, 6, 7, 8; `start4`@5, `end4`@8.
- Twiddle outputs appear on cycles 9, 10, 11, 12; `start4`@9, `end4`@12.
- Latency from x[4] to the first output is 1 cycle. Frame period is 8 cycles.
- Reset: every output reads 0 on the cycle after `rst` is sampled high. Counters go idle and buffers clear to 0.
- Reset mid-operation drops all in-flight data. No partial frame is emitted after `rst` is released.
- `start8` coinciding with the twiddle phase of the previous frame is legal. The two activities do not interact.

## Structure
- Shared package `fft_pkg`:
  - DATA_W, TW_FRAC;
  - the twiddle constants W8_0..W8_3 (re/im);
  - a complex-sample struct typedef.
- One sub-module, `cmul_tw`: a complex × constant-twiddle multiplier with the shift/truncate rule, instantiated for the twiddle phase.
- Two separate 4-entry buffers, IB and DB.
- Output select is driven by an out-counter with states IDLE → SUM(0..3) → TW(0..3) → IDLE. From TW3 the state goes to SUM0 if the next frame's sums are ready.

## Test plan
- Impulse x[0]=(1000,0), others 0:
  - sums (1000,0),0,0,0 on cycles 5–8;
  - twiddled (1000,0),0,0,0 on cycles 9–12;
  - `start4` on cycles 5 and 9, `end4` on cycles 8 and 12.
- Constant x[n]=(100,50) for all n: sums (200,100)×4; twiddled all (0,0).
- x[1]=(16384,0), others 0: sum k=1 is (16384,0); twiddled k=1 is (11585,−11585).
- x[2]=(100,0), others 0: twiddled k=2 is (0,−100). Repeat with x[3]=(16384,0): twiddled k=3 is (−11585,−11585).
- Two back-to-back frames (start8 at cycles 0 and 8): continuous outputs on cycles 5–20 with correct per-frame values and `start4`/`end4` at 5, 9, 13, 17 / 8, 12, 16, 20.
- Reset:
  - `rst` asserted at cycle 6 of a frame: all outputs 0 from the next cycle and no further pulses.
  - A new frame after reset produces the correct results.

Source files
------------

// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
// Shared definitions for the 8-point FFT first stage (fft_8_core).
//   DATA_W   : default width of each real/imag component (signed)
//   TW_FRAC  : fraction bits of the twiddle constants (16384 = 1.0)
//   TW_W     : storage width of one twiddle component
//   W8_k_RE/IM : twiddle factors W8^k = exp(-j*2*pi*k/8), k = 0..3
//   cplx_t   : complex sample at the default DATA_W
//   out_state_e : output sequencer states (IDLE -> SUM0..3 -> TW0..3)
// -----------------------------------------------------------------------------
package fft_pkg;

    localparam int DATA_W  = 32;
    localparam int TW_FRAC = 14;
    localparam int TW_W    = 16;

    localparam logic signed [TW_W-1:0] W8_0_RE =  16'sd16384;
    localparam logic signed [TW_W-1:0] W8_0_IM =  16'sd0;
    localparam logic signed [TW_W-1:0] W8_1_RE =  16'sd11585;
    localparam logic signed [TW_W-1:0] W8_1_IM = -16'sd11585;
    localparam logic signed [TW_W-1:0] W8_2_RE =  16'sd0;
    localparam logic signed [TW_W-1:0] W8_2_IM = -16'sd16384;
    localparam logic signed [TW_W-1:0] W8_3_RE = -16'sd11585;
    localparam logic signed [TW_W-1:0] W8_3_IM = -16'sd11585;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } cplx_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SUM0, ST_SUM1, ST_SUM2, ST_SUM3,
        ST_TW0,  ST_TW1,  ST_TW2,  ST_TW3
    } out_state_e;

endpackage

// File: rtl/fft_8_core_if.sv
// -----------------------------------------------------------------------------
// fft_8_core_if
// Sample bus of the 8-point FFT first stage.
//   start8/end8, A_real/A_img : 8-sample input frame (from the sample source)
//   out_real8/out_img8        : output samples toward the 4-point stage
//   start4/end4               : first/last sample of each 4-sample output frame
// Modports: master = sample source / sink side, slave = fft_8_core.
// -----------------------------------------------------------------------------
interface fft_8_core_if #(
    parameter int DATA_W = fft_pkg::DATA_W
);
    logic                     start8;
    logic                     end8;
    logic signed [DATA_W-1:0] A_real;
    logic signed [DATA_W-1:0] A_img;
    logic signed [DATA_W-1:0] out_real8;
    logic signed [DATA_W-1:0] out_img8;
    logic                     start4;
    logic                     end4;

    modport master (
        output start8, end8, A_real, A_img,
        input  out_real8, out_img8, start4, end4
    );

    modport slave (
        input  start8, end8, A_real, A_img,
        output out_real8, out_img8, start4, end4
    );
endinterface

// File: rtl/cmul_tw.sv
// -----------------------------------------------------------------------------
// cmul_tw
// Combinational complex x constant-twiddle multiplier, y = a * W8^k.
//   k          in  2       : twiddle index 0..3
//   a_re/a_im  in  DATA_W  : complex operand
//   y_re/y_im  out DATA_W  : product, low DATA_W bits
// W0 passes through and W2 (= -j) is a swap/negate, both exact. W1/W3 use a
// full-width signed multiply, sum the partial products, then arithmetic
// shift right by TW_FRAC (floor) and keep the low DATA_W bits.
// -----------------------------------------------------------------------------
module cmul_tw #(
    parameter int DATA_W  = fft_pkg::DATA_W,
    parameter int TW_FRAC = fft_pkg::TW_FRAC
) (
    input  logic [1:0]               k,
    input  logic signed [DATA_W-1:0] a_re,
    input  logic signed [DATA_W-1:0] a_im,
    output logic signed [DATA_W-1:0] y_re,
    output logic signed [DATA_W-1:0] y_im
);
    import fft_pkg::*;

    // One guard bit above the product width so the partial-product sum
    // cannot overflow.
    localparam int PW = DATA_W + TW_W + 1;

    logic signed [PW-1:0] ar_x;
    logic signed [PW-1:0] ai_x;
    logic signed [PW-1:0] wr_x;
    logic signed [PW-1:0] wi_x;
    logic signed [PW-1:0] re_full;
    logic signed [PW-1:0] im_full;

    assign ar_x = PW'(a_re);
    assign ai_x = PW'(a_im);
    assign wr_x = (k == 2'd3) ? PW'(W8_3_RE) : PW'(W8_1_RE);
    assign wi_x = (k == 2'd3) ? PW'(W8_3_IM) : PW'(W8_1_IM);

    assign re_full = ar_x * wr_x - ai_x * wi_x;
    assign im_full = ar_x * wi_x + ai_x * wr_x;

    always_comb begin
        // NOTE: every output gets a default first so no path holds a value, which would infer a latch.
        y_re = a_re;
        y_im = a_im;
        unique case (k)
            2'd1, 2'd3: begin
                y_re = DATA_W'(re_full >>> TW_FRAC);
                y_im = DATA_W'(im_full >>> TW_FRAC);
            end
            2'd2: begin
                y_re = a_im;
                y_im = -a_re;
            end
            default: begin
                y_re = a_re;
                y_im = a_im;
            end
        endcase
    end

endmodule

// File: rtl/fft_8_core.sv
// -----------------------------------------------------------------------------
// fft_8_core
// Radix-2 DIF first stage of an 8-point complex FFT. One 8-sample input frame
// yields two back-to-back 4-sample output frames:
//   sum frame     : x[k] + x[k+4]
//   twiddle frame : (x[k] - x[k+4]) * W8^k
// Ports:
//   clk  in : rising-edge clock
//   rst  in : synchronous active-high reset
//   bus     : fft_8_core_if.slave (input frame in, output frames out)
// Samples n=0..3 land in IB; at n=4..7 the sum is registered straight to the
// output and the difference goes to DB, which the twiddle phase reads back
// four cycles later. DB is separate from IB so the next frame can refill IB
// while the current twiddle phase drains DB.
// -----------------------------------------------------------------------------
module fft_8_core #(
    parameter int DATA_W  = fft_pkg::DATA_W,
    parameter int TW_FRAC = fft_pkg::TW_FRAC
) (
    input  logic         clk,
    input  logic         rst,
    fft_8_core_if.slave  bus
);
    import fft_pkg::*;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } samp_t;

    // Input sequencing
    logic [2:0] in_cnt_q, in_cnt_d;
    logic       in_busy_q, in_busy_d;
    logic       in_valid;
    logic [2:0] cur_n;
    logic [1:0] k_in;
    logic       is_tail;
    samp_t      x;

    // Buffers
    samp_t ib_q [4];
    samp_t ib_d [4];
    samp_t db_q [4];
    samp_t db_d [4];

    // Output sequencing
    out_state_e state_q, state_d;
    samp_t      out_q, out_d;
    logic       start4_q, start4_d;
    logic       end4_q, end4_d;
    logic [1:0] tw_k;
    samp_t      tw_in;
    samp_t      tw_out;

    // end8 only marks the frame end; the counter alone decides framing.
    logic end8_unused;
    assign end8_unused = bus.end8;

    assign x = '{re: bus.A_real, im: bus.A_img};

    // start8 always wins, so a mid-frame start8 restarts at n=0.
    always_comb begin
        in_valid  = bus.start8 | in_busy_q;
        cur_n     = bus.start8 ? 3'd0 : in_cnt_q;
        in_busy_d = 1'b0;
        in_cnt_d  = 3'd0;
        if (in_valid && cur_n != 3'd7) begin
            in_busy_d = 1'b1;
            in_cnt_d  = cur_n + 3'd1;
        end
    end

    assign k_in    = cur_n[1:0];
    assign is_tail = in_valid & cur_n[2];

    always_comb begin
        ib_d = ib_q;
        db_d = db_q;
        if (in_valid && !cur_n[2]) begin
            ib_d[k_in] = x;
        end
        if (is_tail) begin
            db_d[k_in].re = ib_q[k_in].re - x.re;
            db_d[k_in].im = ib_q[k_in].im - x.im;
        end
    end

    // Twiddle index for the sample being computed this cycle (shown next cycle).
    always_comb begin
        tw_k = 2'd0;
        unique case (state_q)
            ST_TW0:  tw_k = 2'd1;
            ST_TW1:  tw_k = 2'd2;
            ST_TW2:  tw_k = 2'd3;
            default: tw_k = 2'd0;
        endcase
    end

    assign tw_in = db_q[tw_k];

    cmul_tw #(
        .DATA_W  (DATA_W),
        .TW_FRAC (TW_FRAC)
    ) u_cmul_tw (
        .k    (tw_k),
        .a_re (tw_in.re),
        .a_im (tw_in.im),
        .y_re (tw_out.re),
        .y_im (tw_out.im)
    );

    // state_d names what the output register shows next cycle. Incoming
    // tail samples take priority, so TW3 flows straight into SUM0 when the
    // next frame's x[4] arrives; an aborted sum phase drops to IDLE.
    always_comb begin
        state_d  = ST_IDLE;
        out_d    = '0;
        start4_d = 1'b0;
        end4_d   = 1'b0;
        if (is_tail) begin
            out_d.re = ib_q[k_in].re + x.re;
            out_d.im = ib_q[k_in].im + x.im;
            start4_d = (k_in == 2'd0);
            end4_d   = (k_in == 2'd3);
            unique case (k_in)
                2'd0:    state_d = ST_SUM0;
                2'd1:    state_d = ST_SUM1;
                2'd2:    state_d = ST_SUM2;
                default: state_d = ST_SUM3;
            endcase
        end else begin
            unique case (state_q)
                ST_SUM3: state_d = ST_TW0;
                ST_TW0:  state_d = ST_TW1;
                ST_TW1:  state_d = ST_TW2;
                ST_TW2:  state_d = ST_TW3;
                default: state_d = ST_IDLE;
            endcase
            if (state_d inside {ST_TW0, ST_TW1, ST_TW2, ST_TW3}) begin
                out_d    = tw_out;
                start4_d = (state_d == ST_TW0);
                end4_d   = (state_d == ST_TW3);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            in_cnt_q  <= 3'd0;
            in_busy_q <= 1'b0;
            state_q   <= ST_IDLE;
            out_q     <= '0;
            start4_q  <= 1'b0;
            end4_q    <= 1'b0;
            // NOTE: the buffers are reset too, because reset must leave them cleared to 0.
            for (int i = 0; i < 4; i++) begin
                ib_q[i] <= '0;
                db_q[i] <= '0;
            end
        end else begin
            in_cnt_q  <= in_cnt_d;
            in_busy_q <= in_busy_d;
            state_q   <= state_d;
            out_q     <= out_d;
            start4_q  <= start4_d;
            end4_q    <= end4_d;
            ib_q      <= ib_d;
            db_q      <= db_d;
        end
    end

    assign bus.out_real8 = out_q.re;
    assign bus.out_img8  = out_q.im;
    assign bus.start4    = start4_q;
    assign bus.end4      = end4_q;

endmodule

// File: tb/tb_fft_8_core.sv
// -----------------------------------------------------------------------------
// tb_fft_8_core
// Scoreboard bench for fft_8_core. Each issued frame pushes its eight expected
// output samples (value, start4/end4, cycle) into a queue; a negedge monitor
// pops the entry due this cycle and otherwise expects an idle (all-zero) bus.
// The reference computes the 8-point DIF first stage as plain complex
// arithmetic on 64-bit integers with the twiddle table W8^k.
// -----------------------------------------------------------------------------
module tb_fft_8_core;
    import fft_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fft_8_core_if #(.DATA_W(DATA_W)) bus ();

    fft_8_core #(
        .DATA_W  (DATA_W),
        .TW_FRAC (TW_FRAC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int    cyc;
        cplx_t v;
        logic  s;
        logic  e;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   n_err  = 0;
    int   n_chk  = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [65:0] got, input logic [65:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, want);
        end
    endtask

    // Monitor: compare the bus against the scoreboard once per cycle.
    always @(negedge clk) begin
        logic [65:0] got;
        exp_t        e;
        if (mon_en) begin
            got = {bus.out_real8, bus.out_img8, bus.start4, bus.end4};
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                e = exp_q.pop_front();
                check("frame_out", got, {e.v.re, e.v.im, e.s, e.e});
            end else begin
                check("idle_out", got, 66'd0);
            end
        end
    end

    // Reference: X_sum[k] = x[k]+x[k+4]; X_tw[k] = (x[k]-x[k+4]) * W8^k with
    // floor((d*W) / 2^TW_FRAC); everything wraps to 32 bits.
    task automatic push_expected(input int c0, input cplx_t x[8], input int n_keep);
        longint wre[4] = '{16384, 11585, 0, -11585};
        longint wim[4] = '{0, -11585, -16384, -11585};
        exp_t   res[8];
        longint ar, ai, br, bi, dr, di;
        for (int k = 0; k < 4; k++) begin
            ar = longint'(x[k].re);
            ai = longint'(x[k].im);
            br = longint'(x[k+4].re);
            bi = longint'(x[k+4].im);
            res[k].cyc  = c0 + 5 + k;
            res[k].v.re = 32'(ar + br);
            res[k].v.im = 32'(ai + bi);
            res[k].s    = (k == 0);
            res[k].e    = (k == 3);
            dr = longint'(int'(ar - br));
            di = longint'(int'(ai - bi));
            res[k+4].cyc  = c0 + 9 + k;
            res[k+4].v.re = 32'((dr * wre[k] - di * wim[k]) >>> TW_FRAC);
            res[k+4].v.im = 32'((dr * wim[k] + di * wre[k]) >>> TW_FRAC);
            res[k+4].s    = (k == 0);
            res[k+4].e    = (k == 3);
        end
        for (int j = 0; j < n_keep; j++) exp_q.push_back(res[j]);
    endtask

    task automatic drive_zero();
        bus.start8 = 1'b0;
        bus.end8   = 1'b0;
        bus.A_real = '0;
        bus.A_img  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            drive_zero();
        end
    endtask

    // Drive one 8-sample frame. With reset_at6 the frame is cut by rst at
    // sample 6, so only the first two sums can ever appear.
    task automatic send_frame(input cplx_t x[8], input bit reset_at6);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) push_expected(cyc, x, reset_at6 ? 2 : 8);
            if (reset_at6 && i == 6) begin
                rst = 1'b1;
                drive_zero();
                break;
            end
            bus.start8 = (i == 0);
            bus.end8   = (i == 7);
            bus.A_real = x[i].re;
            bus.A_img  = x[i].im;
        end
    endtask

    // A frame start followed by only n samples; it never reaches x[4].
    task automatic send_partial(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            bus.start8 = (i == 0);
            bus.end8   = 1'b0;
            bus.A_real = $urandom;
            bus.A_img  = $urandom;
        end
    endtask

    task automatic rand_frame(output cplx_t x[8]);
        for (int i = 0; i < 8; i++) begin
            x[i].re = $urandom;
            x[i].im = $urandom;
        end
    endtask

    task automatic zero_frame(output cplx_t x[8]);
        for (int i = 0; i < 8; i++) x[i] = '0;
    endtask

    initial begin
        cplx_t f[8];

        rst = 1'b1;
        drive_zero();
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);

        // Impulse at n=0.
        zero_frame(f);
        f[0] = '{re: 1000, im: 0};
        send_frame(f, 1'b0);
        idle(8);

        // Constant input: sums double, differences vanish.
        for (int i = 0; i < 8; i++) f[i] = '{re: 100, im: 50};
        send_frame(f, 1'b0);
        idle(8);

        // Single unit sample at n=1, 2, 3 exercises W1, W2, W3.
        zero_frame(f);
        f[1] = '{re: 16384, im: 0};
        send_frame(f, 1'b0);
        idle(8);
        zero_frame(f);
        f[2] = '{re: 100, im: 0};
        send_frame(f, 1'b0);
        idle(8);
        zero_frame(f);
        f[3] = '{re: 16384, im: 0};
        send_frame(f, 1'b0);
        idle(8);

        // Two back-to-back random frames.
        rand_frame(f);
        send_frame(f, 1'b0);
        rand_frame(f);
        send_frame(f, 1'b0);
        idle(8);

        // Aborted partial frame, then a run of back-to-back random frames.
        send_partial(3);
        for (int r = 0; r < 6; r++) begin
            rand_frame(f);
            send_frame(f, 1'b0);
        end
        idle(8);

        // Frame with a start8 a few cycles after the previous end8.
        rand_frame(f);
        send_frame(f, 1'b0);
        idle(2);
        rand_frame(f);
        send_frame(f, 1'b0);
        idle(8);

        // Reset at cycle 6 of a frame, then a clean frame.
        rand_frame(f);
        send_frame(f, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);
        rand_frame(f);
        send_frame(f, 1'b0);
        idle(8);

        mon_en = 1'b0;
        check("scoreboard_drained", 66'(exp_q.size()), 66'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
